// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port instruction/data RAM.
// Round-robin with a bounded burst; read data returns one cycle after the grant.
module mem_arbiter #(
    parameter int WIDTH     = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [WIDTH-1:0]  m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [WIDTH-1:0]  m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [WIDTH-1:0]  mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_gnt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rd_pend;
    logic             r_rd_owner;

    logic w_gnt0;
    logic w_gnt1;
    logic w_any;
    logic w_sel;
    logic w_we;
    logic w_other_req;
    logic w_same_owner;
    logic w_rvalid;

    // NOTE: the grant is combinational, so it is gated by rst_n directly to keep
    // every strobe low during the reset cycle; defaults first avoid latches.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                case (r_state)
                    OWN0: begin
                        if (r_burst_cnt < CNT_LIMIT) w_gnt0 = 1'b1;
                        else                         w_gnt1 = 1'b1;
                    end
                    OWN1: begin
                        if (r_burst_cnt < CNT_LIMIT) w_gnt1 = 1'b1;
                        else                         w_gnt0 = 1'b1;
                    end
                    default: begin
                        if (r_last_gnt) w_gnt0 = 1'b1;
                        else            w_gnt1 = 1'b1;
                    end
                endcase
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
    end

    assign w_any        = w_gnt0 | w_gnt1;
    assign w_sel        = w_gnt1;
    assign w_we         = w_sel ? m1_we : m0_we;
    assign w_other_req  = w_sel ? m0_req : m1_req;
    assign w_same_owner = w_sel ? (r_state == OWN1) : (r_state == OWN0);

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign mem_we    = w_any & w_we;
    assign mem_re    = w_any & ~w_we;
    assign mem_addr  = w_any ? (w_sel ? m1_addr : m0_addr) : '0;
    assign mem_wdata = w_any ? (w_sel ? m1_wdata : m0_wdata) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_gnt  <= 1'b1;
            r_burst_cnt <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_owner  <= 1'b0;
        end else begin
            if (w_any) begin
                r_state    <= w_sel ? OWN1 : OWN0;
                r_last_gnt <= w_sel;
                // Count only contested repeat grants; saturate so a holder never wraps.
                if (w_same_owner && w_other_req)
                    r_burst_cnt <= (r_burst_cnt == CNT_LIMIT) ? r_burst_cnt : r_burst_cnt + 1'b1;
                else
                    r_burst_cnt <= '0;
            end else begin
                r_state     <= IDLE;
                r_burst_cnt <= '0;
            end
            r_rd_pend  <= w_any & ~w_we;
            r_rd_owner <= w_sel;
        end
    end

    assign w_rvalid  = rst_n & r_rd_pend;
    assign m0_rvalid = w_rvalid & ~r_rd_owner;
    assign m1_rvalid = w_rvalid & r_rd_owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
